// File: rtl/mips_ex_pkg.sv
// Shared encodings for the MIPS EX stage: ALU op codes, forwarding selects,
// memory access widths, multiplier FSM states and the EX/MEM control bundle.
package mips_ex_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_SLLV = 5'd11;
    localparam logic [4:0] ALU_SRLV = 5'd12;
    localparam logic [4:0] ALU_SRAV = 5'd13;
    localparam logic [4:0] ALU_LUI  = 5'd14;
    localparam logic [4:0] ALU_MFHI = 5'd15;
    localparam logic [4:0] ALU_MFLO = 5'd16;

    localparam logic [1:0] FWD_IDEX     = 2'b00;
    localparam logic [1:0] FWD_MEM      = 2'b01;
    localparam logic [1:0] FWD_WB       = 2'b10;
    localparam logic [1:0] FWD_IDEX_ALT = 2'b11;

    localparam logic [1:0] DW_BYTE = 2'b00;
    localparam logic [1:0] DW_HALF = 2'b01;
    localparam logic [1:0] DW_WORD = 2'b11;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_BUSY = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       mem_unsigned;
        logic [1:0] data_width;
        logic       mem_to_reg;
        logic       reg_write;
    } ex_mem_ctl_t;

endpackage

// File: rtl/execute_stage_seq_multiplier.sv
// Iterative shift-add multiplier on operand magnitudes; the sign is restored
// on the product output so HI/LO can be loaded directly in the DONE cycle.
module seq_multiplier
    import mips_ex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MULT_CYCLES = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_halt,
    input  logic                      i_start,
    input  logic                      i_unsigned,
    input  logic [DATA_WIDTH-1:0]     i_op_a,
    input  logic [DATA_WIDTH-1:0]     i_op_b,
    output logic                      o_stall_c,
    output logic                      o_done_c,
    output logic [2*DATA_WIDTH-1:0]   o_product_c
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(MULT_CYCLES);

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [DW-1:0]    mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic             neg_q, neg_d;
    logic [DW-1:0]    mag_a_c, mag_b_c;

    assign mag_a_c = (!i_unsigned && i_op_a[DW-1]) ? DW'(~i_op_a + DW'(1)) : i_op_a;
    assign mag_b_c = (!i_unsigned && i_op_b[DW-1]) ? DW'(~i_op_b + DW'(1)) : i_op_b;
    assign o_product_c = neg_q ? PW'(~prod_q + PW'(1)) : prod_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= MULT_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
        end
    end

    // Halt freezes everything and releases the front-end stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        neg_d     = neg_q;
        o_stall_c = 1'b0;
        o_done_c  = 1'b0;
        if (!i_halt) begin
            case (state_q)
                MULT_IDLE: begin
                    if (i_start) begin
                        o_stall_c = 1'b1;
                        mcand_d   = PW'(mag_a_c);
                        mplier_d  = mag_b_c;
                        neg_d     = !i_unsigned && (i_op_a[DW-1] ^ i_op_b[DW-1]);
                        prod_d    = '0;
                        cnt_d     = '0;
                        state_d   = MULT_BUSY;
                    end
                end
                MULT_BUSY: begin
                    o_stall_c = 1'b1;
                    if (mplier_q[0]) prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MULT_CYCLES - 1)) state_d = MULT_DONE;
                end
                MULT_DONE: begin
                    o_done_c = 1'b1;
                    state_d  = MULT_IDLE;
                end
                default: state_d = MULT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, destination select, EX/MEM register
// and HI/LO updated by the sequential multiplier.
module execute_stage
    import mips_ex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MULT_CYCLES = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_halt,
    input  logic [DATA_WIDTH-1:0] i_read_data_1,
    input  logic [DATA_WIDTH-1:0] i_read_data_2,
    input  logic [DATA_WIDTH-1:0] i_immediate,
    input  logic [4:0]            i_shamt,
    input  logic [4:0]            i_rt,
    input  logic [4:0]            i_rd,
    input  logic [1:0]            i_fwd_a,
    input  logic [1:0]            i_fwd_b,
    input  logic [DATA_WIDTH-1:0] i_fwd_mem_data,
    input  logic [DATA_WIDTH-1:0] i_fwd_wb_data,
    input  logic [4:0]            i_ctl_EX_alu_op,
    input  logic                  i_ctl_EX_alu_src,
    input  logic                  i_ctl_EX_reg_dst,
    input  logic                  i_ctl_EX_mult_start,
    input  logic                  i_ctl_EX_mult_unsigned,
    input  logic                  i_ctl_MEM_mem_read_EX,
    input  logic                  i_ctl_MEM_mem_write_EX,
    input  logic                  i_ctl_MEM_unsigned_EX,
    input  logic [1:0]            i_ctl_MEM_data_width_EX,
    input  logic                  i_ctl_WB_mem_to_reg_EX,
    input  logic                  i_ctl_WB_reg_write_EX,
    output logic                  o_ctl_MEM_mem_read_MEM,
    output logic                  o_ctl_MEM_mem_write_MEM,
    output logic                  o_ctl_MEM_unsigned_MEM,
    output logic [1:0]            o_ctl_MEM_data_width_MEM,
    output logic                  o_ctl_WB_mem_to_reg_MEM,
    output logic                  o_ctl_WB_reg_write_MEM,
    output logic [DATA_WIDTH-1:0] o_ALU_result,
    output logic [DATA_WIDTH-1:0] o_data_to_write,
    output logic [4:0]            o_reg_dest,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int unsigned DW = DATA_WIDTH;

    logic [DW-1:0]   op_a_c, fwd_b_c, op_b_c, alu_result_c;
    logic            mult_stall_c, mult_done_c;
    logic [2*DW-1:0] mult_product_c;
    ex_mem_ctl_t     ctl_in_c;

    ex_mem_ctl_t     ctl_q, ctl_d;
    logic [DW-1:0]   alu_result_q, alu_result_d;
    logic [DW-1:0]   data_to_write_q, data_to_write_d;
    logic [4:0]      reg_dest_q, reg_dest_d;
    logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;

    // Operand forwarding; both 00 and 11 take the ID/EX value.
    always_comb begin
        case (i_fwd_a)
            FWD_MEM: op_a_c = i_fwd_mem_data;
            FWD_WB:  op_a_c = i_fwd_wb_data;
            default: op_a_c = i_read_data_1;
        endcase
        case (i_fwd_b)
            FWD_MEM: fwd_b_c = i_fwd_mem_data;
            FWD_WB:  fwd_b_c = i_fwd_wb_data;
            default: fwd_b_c = i_read_data_2;
        endcase
        op_b_c = i_ctl_EX_alu_src ? i_immediate : fwd_b_c;
    end

    always_comb begin
        alu_result_c = '0;
        case (i_ctl_EX_alu_op)
            ALU_ADD:  alu_result_c = op_a_c + op_b_c;
            ALU_SUB:  alu_result_c = op_a_c - op_b_c;
            ALU_AND:  alu_result_c = op_a_c & op_b_c;
            ALU_OR:   alu_result_c = op_a_c | op_b_c;
            ALU_XOR:  alu_result_c = op_a_c ^ op_b_c;
            ALU_NOR:  alu_result_c = ~(op_a_c | op_b_c);
            ALU_SLT:  alu_result_c = DW'($signed(op_a_c) < $signed(op_b_c));
            ALU_SLTU: alu_result_c = DW'(op_a_c < op_b_c);
            ALU_SLL:  alu_result_c = op_b_c << i_shamt;
            ALU_SRL:  alu_result_c = op_b_c >> i_shamt;
            ALU_SRA:  alu_result_c = DW'($signed(op_b_c) >>> i_shamt);
            ALU_SLLV: alu_result_c = op_b_c << op_a_c[4:0];
            ALU_SRLV: alu_result_c = op_b_c >> op_a_c[4:0];
            ALU_SRAV: alu_result_c = DW'($signed(op_b_c) >>> op_a_c[4:0]);
            ALU_LUI:  alu_result_c = {op_b_c[15:0], 16'h0000};
            ALU_MFHI: alu_result_c = hi_q;
            ALU_MFLO: alu_result_c = lo_q;
            default:  alu_result_c = '0;
        endcase
    end

    seq_multiplier #(
        .DATA_WIDTH  (DW),
        .MULT_CYCLES (MULT_CYCLES)
    ) u_mult (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_halt      (i_halt),
        .i_start     (i_ctl_EX_mult_start),
        .i_unsigned  (i_ctl_EX_mult_unsigned),
        .i_op_a      (op_a_c),
        .i_op_b      (op_b_c),
        .o_stall_c   (mult_stall_c),
        .o_done_c    (mult_done_c),
        .o_product_c (mult_product_c)
    );

    assign ctl_in_c = '{
        mem_read:     i_ctl_MEM_mem_read_EX,
        mem_write:    i_ctl_MEM_mem_write_EX,
        mem_unsigned: i_ctl_MEM_unsigned_EX,
        data_width:   i_ctl_MEM_data_width_EX,
        mem_to_reg:   i_ctl_WB_mem_to_reg_EX,
        reg_write:    i_ctl_WB_reg_write_EX
    };

    // A running or retiring MULT sends a bubble downstream; data fields hold.
    always_comb begin
        ctl_d           = ctl_q;
        alu_result_d    = alu_result_q;
        data_to_write_d = data_to_write_q;
        reg_dest_d      = reg_dest_q;
        hi_d            = hi_q;
        lo_d            = lo_q;
        if (!i_halt) begin
            if (mult_stall_c || mult_done_c) begin
                ctl_d = '0;
            end else begin
                ctl_d           = ctl_in_c;
                alu_result_d    = alu_result_c;
                data_to_write_d = fwd_b_c;
                reg_dest_d      = i_ctl_EX_reg_dst ? i_rd : i_rt;
            end
            if (mult_done_c) {hi_d, lo_d} = mult_product_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctl_q           <= '0;
            alu_result_q    <= '0;
            data_to_write_q <= '0;
            reg_dest_q      <= '0;
            hi_q            <= '0;
            lo_q            <= '0;
        end else begin
            ctl_q           <= ctl_d;
            alu_result_q    <= alu_result_d;
            data_to_write_q <= data_to_write_d;
            reg_dest_q      <= reg_dest_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
        end
    end

    assign o_ctl_MEM_mem_read_MEM   = ctl_q.mem_read;
    assign o_ctl_MEM_mem_write_MEM  = ctl_q.mem_write;
    assign o_ctl_MEM_unsigned_MEM   = ctl_q.mem_unsigned;
    assign o_ctl_MEM_data_width_MEM = ctl_q.data_width;
    assign o_ctl_WB_mem_to_reg_MEM  = ctl_q.mem_to_reg;
    assign o_ctl_WB_reg_write_MEM   = ctl_q.reg_write;
    assign o_ALU_result             = alu_result_q;
    assign o_data_to_write          = data_to_write_q;
    assign o_reg_dest               = reg_dest_q;
    assign o_stall                  = mult_stall_c;
    assign o_hi                     = hi_q;
    assign o_lo                     = lo_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Pipeline EX stage of the MIPS core, directly upstream of the memory stage. Selects forwarded operands, runs the ALU, and resolves the destination register. Latches results and the MEM/WB control bundle into the EX/MEM pipeline register. Contains an iterative 32-cycle shift-add multiplier for MULT/MULTU with HI/LO registers, and stalls the front end while it runs.

Parameters:
DATA_WIDTH, 32, datapath width (only 32 supported)
MULT_CYCLES, 32, multiplier iterations; counter width is clog2(MULT_CYCLES)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_halt  in  1  debug halt; freezes all state
i_read_data_1  in  32  rs value from ID/EX
i_read_data_2  in  32  rt value from ID/EX
i_immediate  in  32  extended immediate
i_shamt  in  5  shift amount field
i_rt  in  5  rt index
i_rd  in  5  rd index
i_fwd_a  in  2  operand A select: 00 ID/EX, 01 EX/MEM result, 10 WB data, 11 ID/EX
i_fwd_b  in  2  operand B select, same encoding
i_fwd_mem_data  in  32  EX/MEM ALU result for forwarding
i_fwd_wb_data  in  32  WB write-back data for forwarding
i_ctl_EX_alu_op  in  5  ALU operation, package code
i_ctl_EX_alu_src  in  1  1: B = immediate
i_ctl_EX_reg_dst  in  1  1: dest = rd, 0: dest = rt
i_ctl_EX_mult_start  in  1  instruction in EX is MULT/MULTU
i_ctl_EX_mult_unsigned  in  1  1: MULTU
i_ctl_MEM_mem_read_EX, i_ctl_MEM_mem_write_EX, i_ctl_MEM_unsigned_EX  in  1 each  MEM controls
i_ctl_MEM_data_width_EX  in  2  00 byte, 01 half, 11 word
i_ctl_WB_mem_to_reg_EX, i_ctl_WB_reg_write_EX  in  1 each  WB controls
o_ctl_MEM_mem_read_MEM, o_ctl_MEM_mem_write_MEM, o_ctl_MEM_unsigned_MEM  out  1 each  registered
o_ctl_MEM_data_width_MEM  out  2  registered
o_ctl_WB_mem_to_reg_MEM, o_ctl_WB_reg_write_MEM  out  1 each  registered
o_ALU_result  out  32  registered ALU result
o_data_to_write  out  32  registered forwarded B (before immediate mux)
o_reg_dest  out  5  registered destination index
o_stall  out  1  combinational; hold PC, IF/ID and ID/EX
o_hi, o_lo  out  32 each  HI/LO contents, for debug

Behaviour:
- Reset (async, i_reset_n=0): all registered outputs 0, HI=LO=0, FSM IDLE, counter 0. Reset mid-multiply aborts it; HI/LO stay 0.
- i_halt=1: no register, HI/LO, counter or FSM changes; o_stall=0.
- Operand A = fwd_a mux. Operand B = alu_src ? immediate : fwd_b mux.
- ALU is combinational; the result is registered with 1-cycle latency to EX/MEM.
- ADD/SUB wrap with no overflow trap. SLT is signed, SLTU unsigned; both return 0/1.
- SLL/SRL/SRA shift B by i_shamt. SLLV/SRLV/SRAV shift B by A[4:0].
- LUI = {B[15:0],16'h0}. MFHI/MFLO return HI/LO. Undefined codes return 0.
- reg_dest = reg_dst ? rd : rt.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: mult_start and not halted -> latch |A|, |B| (raw values if unsigned), record the result sign (XOR of operand signs when signed), clear product and counter, go BUSY. o_stall=1 this cycle.
  - BUSY: one shift-add step per cycle; o_stall=1. Counter==MULT_CYCLES-1 -> DONE.
  - DONE: load {HI,LO} with the 64-bit product, two's-complemented if the result sign is negative. o_stall=0; the MULT leaves EX; go IDLE.
  - Total EX occupancy of a MULT: MULT_CYCLES+2 cycles (34 with default).
  - mult_start seen in DONE is not restarted.
- While o_stall=1, EX/MEM loads a bubble: all ctl outputs 0; data outputs hold their last values. The MULT itself also writes a bubble in DONE, since it has no GPR/memory effect.
- MFHI/MFLO immediately after a MULT read the updated HI/LO; the front-end stall guarantees ordering.

Decomposition:
- Package mips_ex_pkg: ALU op codes (ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, SLLV 11, SRLV 12, SRAV 13, LUI 14, MFHI 15, MFLO 16), forwarding select codes, data-width codes, multiplier state encoding.
- Sub-module seq_multiplier: FSM, counter, product registers and sign fix-up, with start/busy/done/product ports.
- ALU is a combinational block inside execute_stage.

Test Plan:
- Reset: drive i_reset_n=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Forwarding: fwd_a=01, i_fwd_mem_data=7; fwd_b=10, i_fwd_wb_data=5; alu_op SUB -> o_ALU_result=2 next cycle.
- Immediate and dest: alu_src=1, imm=0xFFFFFFFC, A=0x100, ADD, reg_dst=0, rt=9 -> result 0xFC, o_reg_dest=9.
  - Also: o_data_to_write equals the forwarded B, not the immediate.
- Shift/compare: SRA B=0x80000000 shamt=4 -> 0xF8000000; SLTU A=1, B=0xFFFFFFFF -> 1; SLT on the same operands -> 0.
- Signed MULT: A=-3, B=7 -> o_stall high for exactly 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - EX/MEM ctl outputs are 0 throughout.
  - Next instruction MFLO -> 0xFFFFFFEB.
- Halt and reset in BUSY: assert i_halt for 5 cycles -> counter frozen and outputs unchanged; total occupancy is 34 non-halt cycles. Then assert i_reset_n=0 while BUSY -> FSM IDLE, HI=LO=0, o_stall=0.
